// File: rtl/logicgates_pkg.sv
// Shared definitions for the logic-gate checker: gate bit positions, FSM states
// and the golden gate function.
package logicgates_pkg;

    localparam int unsigned NUM_GATES = 7;

    // Bit positions within the 7-bit gate vector {xnor,xor,nor,nand,not,or,and}
    localparam int unsigned AND_B  = 0;
    localparam int unsigned OR_B   = 1;
    localparam int unsigned NOT_B  = 2;
    localparam int unsigned NAND_B = 3;
    localparam int unsigned NOR_B  = 4;
    localparam int unsigned XOR_B  = 5;
    localparam int unsigned XNOR_B = 6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Golden gate outputs for one operand pair
    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] y;
        y         = '0;
        y[AND_B]  = a & b;
        y[OR_B]   = a | b;
        y[NOT_B]  = ~a;
        y[NAND_B] = ~(a & b);
        y[NOR_B]  = ~(a | b);
        y[XOR_B]  = a ^ b;
        y[XNOR_B] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/logicgates_ref_model.sv
// Combinational reference: operands in, expected 7-bit gate vector out.
module logicgates_ref_model
    import logicgates_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] y
);

    // Pure function of the operands; kept as a module so other benches can reuse it
    always_comb begin
        y = expected_gates(a, b);
    end

endmodule

// File: rtl/logicgates_checker.sv
// Capture-and-compare stage for logicgates_beh: samples operands and gate outputs,
// checks them against the reference model and accumulates run statistics.
module logicgates_checker
    import logicgates_pkg::*;
#(
    parameter int unsigned NUM_VEC      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter bit          REQ_FULL_COV = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic                 a,
    input  logic                 b,
    input  logic [NUM_GATES-1:0] gates_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [3:0]           cov_map,
    output logic [8:0]           first_fail_vec,
    output logic [CNT_W-1:0]     first_fail_idx
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       accepted_q, accepted_d;
    logic                   stage_vld_q, stage_vld_d;
    logic [8:0]             stage_q, stage_d;
    logic [CNT_W-1:0]       vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [3:0]             cov_map_q, cov_map_d;
    logic [8:0]             ff_vec_q, ff_vec_d;
    logic [CNT_W-1:0]       ff_idx_q, ff_idx_d;
    logic                   pass_q, pass_d;

    logic                   accept;
    logic                   mismatch;
    logic [NUM_GATES-1:0]   expected;

    // Reference for the vector currently sitting in the compare stage
    logicgates_ref_model u_ref (
        .a (stage_q[8]),
        .b (stage_q[7]),
        .y (expected)
    );

    assign accept   = in_valid && (state_q == StRun) && (accepted_q <= LastIdx);
    assign mismatch = |(stage_q[NUM_GATES-1:0] ^ expected);

    // Next-state: capture stage, compare stage, then FSM (run entry clears stats)
    always_comb begin
        state_d     = state_q;
        accepted_d  = accepted_q;
        stage_vld_d = accept;
        stage_d     = accept ? {a, b, gates_y} : stage_q;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        cov_map_d   = cov_map_q;
        ff_vec_d    = ff_vec_q;
        ff_idx_d    = ff_idx_q;
        pass_d      = pass_q;

        if (stage_vld_q) begin
            vec_cnt_d                 = vec_cnt_q + CntOne;
            cov_map_d[stage_q[8:7]]   = 1'b1;
            if (mismatch) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CntOne;
                end
                if (err_cnt_q == '0) begin
                    ff_vec_d = stage_q;
                    ff_idx_d = vec_cnt_q;
                end
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    accepted_d = '0;
                    vec_cnt_d  = '0;
                    err_cnt_d  = '0;
                    cov_map_d  = '0;
                    ff_vec_d   = '0;
                    ff_idx_d   = '0;
                    pass_d     = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    accepted_d = accepted_q + CntOne;
                    if (accepted_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last vector is compared on this edge, so the verdict uses updated stats
                state_d = StDone;
                pass_d  = (err_cnt_d == '0) && ((cov_map_d == 4'hF) || !REQ_FULL_COV);
            end
            default: state_d = StIdle;
        endcase
    end

    // State and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            accepted_q  <= '0;
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            cov_map_q   <= '0;
            ff_vec_q    <= '0;
            ff_idx_q    <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            accepted_q  <= accepted_d;
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            cov_map_q   <= cov_map_d;
            ff_vec_q    <= ff_vec_d;
            ff_idx_q    <= ff_idx_d;
            pass_q      <= pass_d;
        end
    end

    assign busy           = (state_q == StRun) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign vec_cnt        = vec_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign cov_map        = cov_map_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_idx = ff_idx_q;

endmodule
